// File: rtl/ps2_rx.sv
// PS/2 keyboard serial receiver: filters the device clock, assembles 11-bit frames
// and emits each valid scan-code byte with a one-cycle rx_done_tick.
module ps2_rx #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic [7:0] dout
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StDps, StChk, StDone, StErr} state_t;

    logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  f_clk_q, f_clk_d;
    logic                  fall_tick;
    state_t                state_q, state_d;
    logic [10:0]           b_q, b_d;
    logic [3:0]            n_q, n_d;
    logic [TW-1:0]         t_q, t_d;
    logic [7:0]            dout_q, dout_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
            filt_q   <= '1;
            f_clk_q  <= 1'b1;
            state_q  <= StIdle;
            b_q      <= '0;
            n_q      <= '0;
            t_q      <= '0;
            dout_q   <= 8'h00;
        end else begin
            c_meta_q <= ps2c;
            c_sync_q <= c_meta_q;
            d_meta_q <= ps2d;
            d_sync_q <= d_meta_q;
            filt_q   <= filt_d;
            f_clk_q  <= f_clk_d;
            state_q  <= state_d;
            b_q      <= b_d;
            n_q      <= n_d;
            t_q      <= t_d;
            dout_q   <= dout_d;
        end
    end

    // Filtered clock only changes after FILTER_LEN identical samples.
    always_comb begin
        filt_d = {c_sync_q, filt_q[FILTER_LEN-1:1]};
        if (&filt_d) begin
            f_clk_d = 1'b1;
        end else if (~|filt_d) begin
            f_clk_d = 1'b0;
        end else begin
            f_clk_d = f_clk_q;
        end
        fall_tick = f_clk_q & ~f_clk_d;
    end

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        n_d          = n_q;
        t_d          = t_q;
        dout_d       = dout_q;
        rx_done_tick = 1'b0;
        frame_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A falling edge with data high cannot be a start bit; ignore it.
                if (fall_tick && rx_en && !d_sync_q) begin
                    b_d     = {d_sync_q, b_q[10:1]};
                    n_d     = 4'd9;
                    t_d     = '0;
                    state_d = StDps;
                end
            end
            StDps: begin
                if (fall_tick) begin
                    b_d = {d_sync_q, b_q[10:1]};
                    t_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = StChk;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else begin
                    t_d = t_q + 1'b1;
                    if (t_d == T_MAX) begin
                        state_d = StErr;
                    end
                end
            end
            StChk: begin
                if (!b_q[0] && b_q[10] && (^b_q[9:1])) begin
                    dout_d  = b_q[8:1];
                    state_d = StDone;
                end else begin
                    state_d = StErr;
                end
            end
            StDone: begin
                rx_done_tick = 1'b1;
                state_d      = StIdle;
            end
            StErr: begin
                frame_err = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames bit by bit and compares the
// received bytes and error pulses against a frame-level model.
module tb_ps2_rx;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_done_tick;
    logic       frame_err;
    logic [7:0] dout;

    ps2_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  done_q[$];
    int unsigned err_q[$];
    bit          both_seen = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_dout = 8'h00;
    int unsigned last_fall = 0;

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) done_q.push_back(dout);
        if (frame_err === 1'b1) err_q.push_back(cyc);
        if (rx_done_tick === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        done_q.delete();
        err_q.delete();
    endtask

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2d = f[i];
            wait_clks(HALF / 2);
            ps2c = 1'b0;
            last_fall = cyc;
            wait_clks(HALF);
            ps2c = 1'b1;
            wait_clks(HALF / 2);
        end
        ps2d = 1'b1;
    endtask

    // Frame = {stop, parity, data, start}; parity makes the data+parity count odd.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit flip_par,
                                               input bit bad_stop);
        logic par;
        par = (($countones(d) % 2) == 0) ^ flip_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    function automatic bit frame_good(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
    endfunction

    task automatic test_reset();
        int viol;
        reset = 1'b0;
        wait_clks(3);
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %h want 00", dout);
        end
        reset = 1'b1;
        viol = 0;
        for (int i = 0; i < 2000; i++) begin
            wait_clks(1);
            if (dout !== 8'h00 || rx_done_tick !== 1'b0 || frame_err !== 1'b0) viol++;
        end
        n_checks++;
        if (viol !== 0) begin
            n_fail++; $display("FAIL idle_quiet: got %0d bad cycles want 0", viol);
        end
    endtask

    task automatic test_single();
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 10);
        wait_clks(60);
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d want 1", done_q.size());
        end
        if (done_q.size() > 0) begin
            n_checks++;
            if (done_q[0] !== 8'h1C) begin
                n_fail++; $display("FAIL single_data: got %h want 1c", done_q[0]);
            end
        end
        n_checks++;
        if (err_q.size() !== 0) begin
            n_fail++; $display("FAIL single_err: got %0d want 0", err_q.size());
        end
        exp_dout = 8'h1C;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_bits(make_frame(8'hF0, 1'b0, 1'b0), 0, 10);
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 10);
        wait_clks(60);
        n_checks++;
        if (done_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 2", done_q.size());
        end
        if (done_q.size() == 2) begin
            n_checks++;
            if (done_q[0] !== 8'hF0 || done_q[1] !== 8'h1C) begin
                n_fail++; $display("FAIL b2b_data: got %h %h want f0 1c", done_q[0], done_q[1]);
            end
        end
        exp_dout = 8'h1C;
    endtask

    task automatic test_frame_errors();
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_bits(make_frame(8'h1C, k == 0, k == 1), 0, 10);
            wait_clks(60);
            n_checks++;
            if (err_q.size() !== 1 || done_q.size() !== 0) begin
                n_fail++;
                $display("FAIL frame_err_%0d: got err=%0d done=%0d want err=1 done=0",
                         k, err_q.size(), done_q.size());
            end
            n_checks++;
            if (dout !== exp_dout) begin
                n_fail++; $display("FAIL frame_err_dout_%0d: got %h want %h", k, dout, exp_dout);
            end
        end
    endtask

    task automatic test_timeout_glitch();
        int unsigned fall5;
        int unsigned delay;
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 4);
        fall5 = last_fall;
        wait_clks(TO + 100);
        n_checks++;
        if (err_q.size() !== 1 || done_q.size() !== 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err=%0d done=%0d want err=1 done=0",
                     err_q.size(), done_q.size());
        end
        if (err_q.size() > 0) begin
            delay = err_q[0] - fall5;
            n_checks++;
            if (delay < FL + TO - 2 || delay > FL + TO + 8) begin
                n_fail++;
                $display("FAIL timeout_delay: got %0d want %0d..%0d", delay, FL + TO - 2,
                         FL + TO + 8);
            end
        end
        clear_mon();
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 0, 10);
        wait_clks(60);
        n_checks++;
        if (done_q.size() !== 1 || err_q.size() !== 0) begin
            n_fail++;
            $display("FAIL after_timeout_count: got done=%0d err=%0d want 1 0",
                     done_q.size(), err_q.size());
        end
        n_checks++;
        if (dout !== 8'h5A) begin
            n_fail++; $display("FAIL after_timeout_data: got %h want 5a", dout);
        end
        exp_dout = 8'h5A;
        // Data held low so an accepted glitch would start a frame and later time out.
        clear_mon();
        ps2d = 1'b0;
        wait_clks(10);
        ps2c = 1'b0;
        wait_clks(3);
        ps2c = 1'b1;
        wait_clks(30);
        ps2d = 1'b1;
        wait_clks(TO + 100);
        n_checks++;
        if (done_q.size() !== 0 || err_q.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch: got done=%0d err=%0d want 0 0", done_q.size(), err_q.size());
        end
    endtask

    task automatic test_rx_en();
        logic [7:0] d;
        d = 8'($urandom);
        clear_mon();
        rx_en = 1'b0;
        send_bits(make_frame(d, 1'b0, 1'b0), 0, 10);
        wait_clks(TO + 100);
        n_checks++;
        if (done_q.size() !== 0 || err_q.size() !== 0 || dout !== exp_dout) begin
            n_fail++;
            $display("FAIL rx_en_off: got done=%0d err=%0d dout=%h want 0 0 %h",
                     done_q.size(), err_q.size(), dout, exp_dout);
        end
        // Remaining bits of 0xF0 after bit 4 are all high, so none look like a start bit.
        clear_mon();
        send_bits(make_frame(8'hF0, 1'b0, 1'b0), 0, 4);
        rx_en = 1'b1;
        send_bits(make_frame(8'hF0, 1'b0, 1'b0), 5, 10);
        wait_clks(TO + 100);
        n_checks++;
        if (done_q.size() !== 0 || err_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rx_en_mid: got done=%0d err=%0d want 0 0", done_q.size(), err_q.size());
        end
        clear_mon();
        send_bits(make_frame(8'h29, 1'b0, 1'b0), 0, 10);
        wait_clks(60);
        n_checks++;
        if (done_q.size() !== 1 || dout !== 8'h29) begin
            n_fail++;
            $display("FAIL rx_en_next: got done=%0d dout=%h want 1 29", done_q.size(), dout);
        end
        exp_dout = 8'h29;
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [10:0] f;
        int          kind;
        bit          good;
        for (int it = 0; it < 8; it++) begin
            d = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            f = make_frame(d, kind == 1, kind == 2);
            good = frame_good(f);
            clear_mon();
            send_bits(f, 0, 10);
            wait_clks(60);
            if (good) exp_dout = d;
            n_checks++;
            if (done_q.size() !== (good ? 1 : 0) || err_q.size() !== (good ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand_%0d_pulses: data=%h got done=%0d err=%0d want good=%0d",
                         it, d, done_q.size(), err_q.size(), good);
            end
            n_checks++;
            if (dout !== exp_dout) begin
                n_fail++; $display("FAIL rand_%0d_dout: got %h want %h", it, dout, exp_dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 5);
        reset = 1'b0;
        wait_clks(3);
        n_checks++;
        if (dout !== 8'h00 || rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got dout=%h done=%b err=%b want 00 0 0",
                     dout, rx_done_tick, frame_err);
        end
        reset = 1'b1;
        exp_dout = 8'h00;
        wait_clks(TO + 100);
        n_checks++;
        if (done_q.size() !== 0 || err_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got done=%0d err=%0d want 0 0",
                     done_q.size(), err_q.size());
        end
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 10);
        wait_clks(60);
        n_checks++;
        if (done_q.size() !== 1 || dout !== 8'h1C || err_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got done=%0d err=%0d dout=%h want 1 0 1c",
                     done_q.size(), err_q.size(), dout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_errors();
        test_timeout_glitch();
        test_rx_en();
        test_random();
        test_reset_mid();
        n_checks++;
        if (both_seen !== 1'b0) begin
            n_fail++; $display("FAIL exclusive_pulses: got both high want never");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard serial receiver. It filters the device-driven ps2c line, samples ps2d on each filtered falling edge, and assembles the 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop). It delivers each valid scan-code byte on dout with a one-cycle rx_done_tick. It sits directly upstream of flag_buf: rx_done_tick drives set_flag and dout drives din.

## Interface
- FILTER_LEN, 8: number of consecutive identical ps2c samples needed to change the filtered clock level (2..16).
- TIMEOUT, 100000: clocks allowed between falling edges inside a frame before the frame is aborted (≥ 2; 2 ms at 50 MHz).
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ps2c  in  1  raw PS/2 clock pin, asynchronous.
- ps2d  in  1  raw PS/2 data pin, asynchronous.
- rx_en  in  1  receive enable; a new frame starts only while high.
- rx_done_tick  out  1  one-cycle pulse, valid frame received.
- frame_err  out  1  one-cycle pulse, bad start/stop/parity or timeout.
- dout  out  8  last valid data byte.

## Operation
- Sync: ps2c and ps2d each pass through a 2-flop synchronizer.
- Filter: a FILTER_LEN-bit shift register takes the synced ps2c each cycle.
  - All ones sets the filtered clock f_clk to 1. All zeros sets it to 0. Any other pattern holds f_clk.
  - fall_tick = f_clk_reg & ~f_clk_next, high for one cycle per filtered falling edge.
- Shift register b[10:0]: on each accepted fall_tick, b <= {ps2d_sync, b[10:1]}. After 11 bits: b[0] start, b[8:1] data, b[9] parity, b[10] stop.
- Bit counter n (4 bit) and timeout counter t (width ceil(log2(TIMEOUT))).
- FSM states:
  - IDLE: on fall_tick & rx_en & ps2d_sync==0, shift in the start bit, set n=9, clear t, go to DPS.
    - fall_tick with ps2d_sync==1 is a glitch: stay in IDLE, no pulse.
    - fall_tick with rx_en==0 is ignored.
  - DPS: on fall_tick, shift, clear t. If n==0 go to CHK, else n--.
    - With no fall_tick, t++. If t reaches TIMEOUT-1, go to ERR.
    - rx_en is not checked in DPS; a started frame always finishes or times out.
  - CHK (1 cycle): the frame is good when b[0]==0, b[10]==1 and ^b[9:1]==1 (odd parity).
    - Good: dout <= b[8:1], go to DONE.
    - Bad: go to ERR.
  - DONE (1 cycle): rx_done_tick=1, go to IDLE.
  - ERR (1 cycle): frame_err=1, dout unchanged, go to IDLE.
- rx_done_tick and frame_err are Moore outputs of DONE/ERR. They are never high together.
- dout holds its value until the next good frame.
- An asynchronous reset assertion at any point, including mid-frame, returns to IDLE and discards partial bits.

## Timing
- Reset values: state IDLE, dout 8'h00, rx_done_tick 0, frame_err 0, b 0, n 0, t 0, filter register all ones, f_clk 1, synchronizers 1.
- fall_tick asserts FILTER_LEN+3 clocks (±1) after the ps2c pin falls. ps2c low pulses shorter than FILTER_LEN clocks produce no tick.
- ps2d is sampled at fall_tick. The device holds ps2d ≥ 5 µs after its ps2c falling edge, which exceeds the filter delay for FILTER_LEN ≤ 16 at 50 MHz.
- Good frame: CHK is 1 cycle after the 11th fall_tick. DONE, with rx_done_tick high and dout already updated, follows in the next cycle.
- Bad frame: ERR, with frame_err high, is 2 cycles after the 11th fall_tick.
- Timeout: ERR is entered TIMEOUT clocks after the last fall_tick.
- Back-to-back frames: IDLE is re-entered 3 cycles after the 11th edge, far shorter than the PS/2 inter-frame gap. No frame is lost.

## Test plan
Bench settings: FILTER_LEN=8, TIMEOUT=1000, ps2c half-period 40 clk.
- Reset then idle: hold reset=0 for 3 clk, then release. Require dout=8'h00, rx_done_tick=0 and frame_err=0 through 2000 idle clocks.
- Single frame: send 0x1C (parity 0). Require exactly one rx_done_tick, dout=8'h1C in that cycle, and frame_err never high.
- Back-to-back: send 0xF0 (parity 1), then 0x1C. Require two rx_done_tick pulses with dout 8'hF0 then 8'h1C.
- Frame errors:
  - Send 0x1C with parity 1: one frame_err pulse, no rx_done_tick, dout keeps its prior value.
  - Send 0x1C with stop bit 0: same response.
- Timeout and glitch:
  - Stop ps2c after 5 bits: frame_err 1000 clk after the 5th tick.
  - Then send 0x5A: rx_done_tick with dout=8'h5A.
  - A 3-clk ps2c low glitch produces no tick.
- rx_en and reset:
  - With rx_en=0, send a full frame: no outputs.
  - Raise rx_en mid-frame of a second frame: still nothing for that frame. The next frame is received.
  - Assert reset after 6 bits: state IDLE and dout=8'h00, then a fresh 0x1C is received correctly.
